jam_scheduler: RTL
==================

# jam_scheduler

Round-robin scheduler for the intersection during jam operation. It shares the single "green" resource among the four jammed approaches, enforcing a minimum and maximum green time and an all-red clearance interval between grants. It sits beside the normal-operation sequencer. The control unit enables it while in JAM state, and its allow outputs feed the control unit's jam-side allow inputs.

## Interface
Parameters:
- GREEN_CYCLES, 16: maximum green length per grant, in cycles. Must be ≥ MIN_GREEN and ≤ 2^CNT_W.
- MIN_GREEN, 4: minimum green length per grant. Must be ≥ 1.
- CLEAR_CYCLES, 2: all-red cycles after every grant. Must be ≥ 1.
- CNT_W, 8: width of the phase counter.

Ports:
- clk, in, 1: clock; everything is on the rising edge.
- rst, in, 1: reset; one clock, synchronous, active-high.
- jam_op_en, in, 1: enable from the control unit.
- jam_sensor_0..jam_sensor_3, in, 1 each: jam requests for approaches 0–3.
- allow_0..allow_3, out, 1 each: green for an approach; registered; at most one is high.
- grant_id, out, 2: index of the current or last granted approach.
- grant_valid, out, 1: high while in GRANT.
- clearing, out, 1: high while in CLEAR.

## Operation
- **State machine:** IDLE, GRANT, CLEAR, plus the registers rr_ptr[1:0] and cnt[CNT_W-1:0].
- **Arbitration:** search sensors in order rr_ptr, rr_ptr+1, … (mod 4). The first one asserted wins.
- **IDLE:** all allows 0. If jam_op_en and any sensor is asserted, arbitrate, load grant_id, set cnt=0, and go to GRANT.
- **GRANT:**
  - allow_[grant_id]=1 and grant_valid=1; cnt increments each cycle.
  - Exit to CLEAR when any of these holds:
    - cnt==GREEN_CYCLES-1;
    - jam_sensor_[grant_id]==0 and cnt≥MIN_GREEN-1;
    - jam_op_en==0, which exits immediately regardless of MIN_GREEN.
  - On exit: rr_ptr=grant_id+1 (mod 4, so 3 wraps to 0) and cnt=0.
- **CLEAR:** all allows 0 and clearing=1; cnt increments. CLEAR always completes, even if jam_op_en drops. On the cycle where cnt==CLEAR_CYCLES-1:
  - if jam_op_en and any sensor is asserted, arbitrate and go directly to GRANT (cnt=0);
  - otherwise go to IDLE.
- **Request changes during a grant:** sensors that assert during another approach's grant wait. A sensor that drops before MIN_GREEN is still served MIN_GREEN cycles.
- **Simultaneous requests:** resolved only by rr_ptr. With all four held, the service order from reset is 0,1,2,3,0,…
- **Reset (applies mid-operation too):** state=IDLE, rr_ptr=0, cnt=0, grant_id=0, all allows 0, grant_valid=0, clearing=0.
- **Safety invariant:** never more than one allow high. At least CLEAR_CYCLES all-low cycles between any two grants.

## Timing
- **Grant latency:** a request sampled in IDLE at edge N gives allow high from edge N+1 (1-cycle latency).
- **Green length:** allow stays high for exactly cnt_exit+1 cycles.
  - Range: MIN_GREEN to GREEN_CYCLES when jam_op_en stays high.
  - If jam_op_en drops, allow goes low at the next edge.
- **Clearance:** exactly CLEAR_CYCLES cycles. The back-to-back gap between grants is CLEAR_CYCLES, with no idle cycle.
- **Output timing:** all outputs are registered with no combinational input-to-output paths. grant_id holds its value through CLEAR and IDLE.

## Test plan
1. Hold rst high for 2 cycles with all sensors high -> all outputs 0. After release, assert only jam_sensor_2 -> allow_2 high 1 cycle later for 16 cycles, then clearing high for 2 cycles, then IDLE.
2. Hold all four sensors high -> grants 0,1,2,3,0, each 16 cycles, separated by exactly 2 all-low cycles. One-hot checker on the allows never fires.
3. Pulse jam_sensor_1 for 1 cycle -> allow_1 high for 4 cycles. Separately, drop jam_sensor_1 during the 10th green cycle -> allow_1 high for exactly 10 cycles.
4. Drop jam_op_en during green cycle 5 of approach 0 -> allow_0 low at the next edge, 2 CLEAR cycles, then IDLE. No grant while en stays low even though sensors stay high.
5. Assert rst mid-GRANT on approach 2 with sensors 1 and 3 high -> outputs 0 next edge. After release, the next grant goes to 1 (rr_ptr reset to 0).
6. Wrap check: grant on approach 3 completes while sensors 0 and 3 are high -> next grant is 0, then 3.

Source files
------------

// File: rtl/jam_scheduler.sv
// jam_scheduler: round-robin green arbiter for jammed approaches with min/max green and all-red clearance
module jam_scheduler #(
   parameter int GREEN_CYCLES = 16,
   parameter int MIN_GREEN    = 4,
   parameter int CLEAR_CYCLES = 2,
   parameter int CNT_W        = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       jam_op_en,
   input  logic       jam_sensor_0,
   input  logic       jam_sensor_1,
   input  logic       jam_sensor_2,
   input  logic       jam_sensor_3,
   output logic       allow_0,
   output logic       allow_1,
   output logic       allow_2,
   output logic       allow_3,
   output logic [1:0] grant_id,
   output logic       grant_valid,
   output logic       clearing
);
   typedef enum logic [1:0] {IDLE, GRANT, CLEAR} state_t;
   state_t           state_q, state_d;
   logic [1:0]       rr_ptr_q, rr_ptr_d, grant_id_q, grant_id_d, pick, idx;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       sens, allow_q, allow_d;
   logic             grant_valid_q, grant_valid_d, clearing_q, clearing_d;
   logic             go, grant_end, clear_end;
   assign sens      = {jam_sensor_3, jam_sensor_2, jam_sensor_1, jam_sensor_0};
   assign go        = jam_op_en && |sens;
   assign grant_end = !jam_op_en || cnt_q == CNT_W'(GREEN_CYCLES - 1) ||
                      (!sens[grant_id_q] && cnt_q >= CNT_W'(MIN_GREEN - 1));
   assign clear_end = cnt_q == CNT_W'(CLEAR_CYCLES - 1);
   // scanning offsets high to low leaves the lowest asserted offset from rr_ptr as winner
   always_comb begin
      pick = rr_ptr_q;
      idx  = rr_ptr_q;
      for (int i = 3; i >= 0; i--) begin
         idx = rr_ptr_q + 2'(i);
         pick = sens[idx] ? idx : pick;
      end
   end
   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      grant_id_d = grant_id_q;
      cnt_d      = cnt_q + 1'b1;
      case (state_q)
         IDLE: begin
            cnt_d      = '0;
            state_d    = go ? GRANT : IDLE;
            grant_id_d = go ? pick : grant_id_q;
         end
         GRANT: begin
            state_d  = grant_end ? CLEAR : GRANT;
            rr_ptr_d = grant_end ? grant_id_q + 2'd1 : rr_ptr_q;
            cnt_d    = grant_end ? '0 : cnt_q + 1'b1;
         end
         CLEAR: begin
            state_d    = !clear_end ? CLEAR : (go ? GRANT : IDLE);
            grant_id_d = (clear_end && go) ? pick : grant_id_q;
            cnt_d      = clear_end ? '0 : cnt_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase
      allow_d       = (state_d == GRANT) ? 4'b0001 << grant_id_d : 4'b0000;
      grant_valid_d = state_d == GRANT;
      clearing_d    = state_d == CLEAR;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         rr_ptr_q      <= '0;
         grant_id_q    <= '0;
         cnt_q         <= '0;
         allow_q       <= '0;
         grant_valid_q <= 1'b0;
         clearing_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         rr_ptr_q      <= rr_ptr_d;
         grant_id_q    <= grant_id_d;
         cnt_q         <= cnt_d;
         allow_q       <= allow_d;
         grant_valid_q <= grant_valid_d;
         clearing_q    <= clearing_d;
      end
   end
   assign {allow_3, allow_2, allow_1, allow_0} = allow_q;
   assign grant_id    = grant_id_q;
   assign grant_valid = grant_valid_q;
   assign clearing    = clearing_q;
endmodule
